nice_uid_stamper: RTL and testbench

// - Hardware counterpart of the per-name unique-ID scheme: N request classes, each with its own incremental UID sequence counting up from 0.
// - Sits upstream of transaction producers/monitors. Arbitrates requests round-robin and issues one {class, uid} stamp per cycle on a registered valid/ready output.

---
 rtl/nice_uid_pkg.sv | 12 +
 rtl/nice_rr_arbiter.sv | 33 +++
 rtl/nice_uid_stamper.sv | 61 ++++++
 tb/tb_nice_uid_stamper.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/nice_uid_pkg.sv
// nice_uid_pkg: default sizes and stamp types for the per-class UID stamper.
package nice_uid_pkg;
  localparam int DEF_NUM_CLASSES = 4;
  localparam int DEF_UID_W = 16;
  typedef logic [DEF_UID_W-1:0] uid_t;
  typedef logic [$clog2(DEF_NUM_CLASSES)-1:0] class_idx_t;
  typedef struct packed {
    class_idx_t cls;
    uid_t uid;
    logic wrap;
  } uid_stamp_t;
endpackage

// File: rtl/nice_rr_arbiter.sv
// nice_rr_arbiter: round-robin grant starting at a pointer that moves past the winner on advance.
module nice_rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] ptr;
  logic found;
  int j;
  always_comb begin
    grant = '0;
    grant_idx = '0;
    found = 1'b0;
    j = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        grant[j] = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (advance) ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/nice_uid_stamper.sv
// nice_uid_stamper: per-class UID counters behind a round-robin arbiter, one registered stamp per cycle.
module nice_uid_stamper
  import nice_uid_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int UID_W = DEF_UID_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CLASSES-1:0]         req_valid,
  output logic [NUM_CLASSES-1:0]         req_ready,
  input  logic [NUM_CLASSES-1:0]         cnt_clear,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(NUM_CLASSES)-1:0] out_class,
  output logic [UID_W-1:0]               out_uid,
  output logic                           out_wrap
);
  localparam int CW = $clog2(NUM_CLASSES);
  typedef struct packed {
    logic [CW-1:0] cls;
    logic [UID_W-1:0] uid;
    logic wrap;
  } stamp_t;
  logic [UID_W-1:0] cnt [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] grant;
  logic [CW-1:0] g;
  logic [UID_W-1:0] cur;
  logic load, accept;
  stamp_t stamp;
  assign load = rst_n && (!out_valid || out_ready);
  assign req_ready = grant & {NUM_CLASSES{load}};
  assign accept = |req_ready;
  // a same-cycle clear wins over the stored count
  assign cur = cnt_clear[g] ? '0 : cnt[g];
  assign out_class = stamp.cls;
  assign out_uid = stamp.uid;
  assign out_wrap = stamp.wrap;
  nice_rr_arbiter #(.N(NUM_CLASSES)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req(req_valid),
    .advance(accept),
    .grant(grant),
    .grant_idx(g)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      stamp <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        stamp <= '{cls: g, uid: cur, wrap: &cur};
      end else if (out_ready) out_valid <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++)
        if (accept && g == CW'(i)) cnt[i] <= cur + 1'b1;
        else if (cnt_clear[i]) cnt[i] <= '0;
    end
endmodule

// File: tb/tb_nice_uid_stamper.sv
// tb_nice_uid_stamper: directed scoreboard bench for the UID stamper (4 classes, 4-bit UIDs).
module tb_nice_uid_stamper;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_valid, req_ready, cnt_clear;
  logic out_valid, out_ready, out_wrap;
  logic [1:0] out_class;
  logic [3:0] out_uid;
  logic [6:0] q[$];
  int checks = 0;
  int errors = 0;
  nice_uid_stamper #(.NUM_CLASSES(4), .UID_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .cnt_clear(cnt_clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_class(out_class),
    .out_uid(out_uid),
    .out_wrap(out_wrap)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  // scoreboard: every handed-off stamp must match the oldest expected one
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL stamp: observed %0h expected none", {out_class, out_uid, out_wrap});
      end else chk("stamp", {25'd0, out_class, out_uid, out_wrap}, {25'd0, q.pop_front()});
    end
  task automatic drive(input logic [3:0] rv, input logic ordy, input logic [3:0] clr);
    req_valid = rv;
    out_ready = ordy;
    cnt_clear = clr;
  endtask
  task automatic next;
    @(posedge clk);
    #2;
  endtask
  task automatic acc(input logic [3:0] rv, input logic [3:0] clr, input int cls, input int uid, input logic wrap);
    logic [3:0] u = 4'(uid);
    logic [1:0] c = 2'(cls);
    drive(rv, 1'b1, clr);
    #1;
    chk("req_ready", {28'd0, req_ready}, 32'(4'b0001 << cls));
    q.push_back({c, u, wrap});
    next();
    chk("out_valid_after_accept", {31'd0, out_valid}, 32'd1);
  endtask
  task automatic idle;
    drive(4'b0000, 1'b1, 4'b0000);
    next();
    chk("out_valid_idle", {31'd0, out_valid}, 32'd0);
  endtask
  initial begin
    rst_n = 1'b0;
    drive(4'b1111, 1'b1, 4'b0000);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_class", {30'd0, out_class}, 32'd0);
    chk("rst_uid", {28'd0, out_uid}, 32'd0);
    chk("rst_wrap", {31'd0, out_wrap}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    next();
    chk("rst_valid_edge", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    // contention from pointer 0
    acc(4'b1111, 4'b0000, 0, 0, 1'b0);
    acc(4'b1111, 4'b0000, 1, 0, 1'b0);
    acc(4'b1111, 4'b0000, 2, 0, 1'b0);
    acc(4'b1111, 4'b0000, 3, 0, 1'b0);
    acc(4'b1111, 4'b0000, 0, 1, 1'b0);
    // single class, back to back
    acc(4'b0001, 4'b0000, 0, 2, 1'b0);
    acc(4'b0001, 4'b0000, 0, 3, 1'b0);
    acc(4'b0001, 4'b0000, 0, 4, 1'b0);
    idle();
    // backpressure: pointer sits at class 1
    drive(4'b1111, 1'b0, 4'b0000);
    #1;
    chk("bp_first_grant", {28'd0, req_ready}, 32'h2);
    q.push_back({2'd1, 4'd1, 1'b0});
    next();
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 1'b0, 4'b0000);
      #1;
      chk("bp_req_ready", {28'd0, req_ready}, 32'd0);
      chk("bp_stamp", {24'd0, out_valid, out_class, out_uid, out_wrap}, {24'd0, 1'b1, 2'd1, 4'd1, 1'b0});
      next();
    end
    acc(4'b1111, 4'b0000, 2, 1, 1'b0);
    idle();
    // wrap on class 2 after clearing it
    drive(4'b0000, 1'b1, 4'b0100);
    next();
    for (int i = 0; i < 17; i++) acc(4'b0100, 4'b0000, 2, i % 16, i == 15);
    idle();
    // clear together with accept on class 1 once its count reaches 7
    for (int i = 2; i < 7; i++) acc(4'b0010, 4'b0000, 1, i, 1'b0);
    acc(4'b0010, 4'b0010, 1, 0, 1'b0);
    acc(4'b0010, 4'b0000, 1, 1, 1'b0);
    idle();
    // clear alone leaves a held stamp untouched
    acc(4'b1000, 4'b0000, 3, 1, 1'b0);
    drive(4'b0000, 1'b0, 4'b1000);
    next();
    chk("clear_held_stamp", {24'd0, out_valid, out_class, out_uid, out_wrap}, {24'd0, 1'b1, 2'd3, 4'd1, 1'b0});
    idle();
    acc(4'b1000, 4'b0000, 3, 0, 1'b0);
    idle();
    // reset with a pending stamp that is never consumed
    drive(4'b1111, 1'b0, 4'b0000);
    next();
    chk("pending_before_reset", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_drop", {31'd0, out_valid}, 32'd0);
    chk("reset_req_ready", {28'd0, req_ready}, 32'd0);
    next();
    rst_n = 1'b1;
    acc(4'b1111, 4'b0000, 0, 0, 1'b0);
    acc(4'b1111, 4'b0000, 1, 0, 1'b0);
    acc(4'b1111, 4'b0000, 2, 0, 1'b0);
    acc(4'b1111, 4'b0000, 3, 0, 1'b0);
    idle();
    next();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
